// File: rtl/noc_port_arbiter_pkg.sv
// Shared types and limits for the NoC port arbiter slice.
package noc_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_MAX_REQ = 8;

endpackage

// File: rtl/noc_port_arbiter_skid_buf.sv
// Two-entry AXI-Stream register slice: registered outputs, full throughput,
// and a skid entry that catches the beat in flight when the sink stalls.
module axis_skid_buf #(
  parameter int unsigned W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         s_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Output stage refills from the skid entry first so beat order is kept.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    s_acc        = s_valid & ~skid_valid_q;
    if (m_ready || !out_valid_q) begin
      out_valid_d  = skid_valid_q | s_acc;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_data_d = skid_data_q;
      end else if (s_acc) begin
        out_data_d = s_data;
      end
    end else if (s_acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  assign s_ready = ~skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-atomic round-robin arbiter sharing one mesh router input port
// between NUM_REQ local AXI-Stream masters, with a registered output stage.
module noc_port_arbiter
  import noc_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TDATAW   = 32,
  parameter int unsigned TDESTW   = 4,
  parameter int unsigned PKT_CNTW = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_tvalid,
  output logic [NUM_REQ-1:0]           req_tready,
  input  logic [NUM_REQ*TDATAW-1:0]    req_tdata,
  input  logic [NUM_REQ-1:0]           req_tlast,
  input  logic [NUM_REQ*TDESTW-1:0]    req_tdest,
  output logic                         axis_m_tvalid,
  input  logic                         axis_m_tready,
  output logic [TDATAW-1:0]            axis_m_tdata,
  output logic                         axis_m_tlast,
  output logic [TDESTW-1:0]            axis_m_tdest,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [PKT_CNTW-1:0]          pkt_cnt
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned PLW = TDATAW + TDESTW + 1;

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                first_q, first_d;
  logic [TDESTW-1:0]   dest_q, dest_d;
  logic [PKT_CNTW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [TDATAW-1:0]   data_a [NUM_REQ];
  logic [TDESTW-1:0]   dest_a [NUM_REQ];
  logic                vld_sel, last_sel, beat_acc;
  logic                buf_s_valid, buf_s_ready;
  logic [PLW-1:0]      buf_s_data, buf_m_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = req_tdata[i*TDATAW +: TDATAW];
    assign dest_a[i] = req_tdest[i*TDESTW +: TDESTW];
  end

  // First valid requester strictly after ptr, wrapping back to ptr itself.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NUM_REQ);
      if (!found && vld[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign vld_sel  = req_tvalid[grant_q];
  assign last_sel = req_tlast[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IDW'(NUM_REQ - 1);
      first_q   <= 1'b0;
      dest_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      first_q   <= first_d;
      dest_q    <= dest_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (enable && |req_tvalid) state_d = ARB_STREAM;
      ARB_STREAM: if (beat_acc && last_sel)  state_d = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping, requester handshake and packet-wide TDEST latch.
  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    first_d     = first_q;
    dest_d      = dest_q;
    req_tready  = '0;
    buf_s_valid = 1'b0;
    beat_acc    = 1'b0;
    busy        = (state_q == ARB_STREAM);
    buf_s_data  = {last_sel, (first_q ? dest_a[grant_q] : dest_q), data_a[grant_q]};
    pkt_cnt_d   = pkt_cnt_q + PKT_CNTW'(axis_m_tvalid & axis_m_tready & axis_m_tlast);
    if (state_q == ARB_IDLE) begin
      if (enable && |req_tvalid) begin
        grant_d  = rr_pick(req_tvalid, rr_ptr_q);
        rr_ptr_d = grant_d;
        first_d  = 1'b1;
      end
    end else begin
      req_tready  = NUM_REQ'(buf_s_ready) << grant_q;
      buf_s_valid = vld_sel;
      beat_acc    = vld_sel & buf_s_ready;
      if (beat_acc) begin
        first_d = 1'b0;
        if (first_q) dest_d = dest_a[grant_q];
      end
    end
  end

  axis_skid_buf #(
    .W (PLW)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (buf_s_valid),
    .s_ready (buf_s_ready),
    .s_data  (buf_s_data),
    .m_valid (axis_m_tvalid),
    .m_ready (axis_m_tready),
    .m_data  (buf_m_data)
  );

  assign {axis_m_tlast, axis_m_tdest, axis_m_tdata} = buf_m_data;
  assign grant_id = grant_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: per-requester beat queues drive the
// inputs, an output scoreboard checks order, payload, TDEST and grant.
module tb_noc_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req_tvalid;
  logic [3:0]   req_tready;
  logic [127:0] req_tdata;
  logic [3:0]   req_tlast;
  logic [15:0]  req_tdest;
  logic         axis_m_tvalid;
  logic         axis_m_tready;
  logic [31:0]  axis_m_tdata;
  logic         axis_m_tlast;
  logic [3:0]   axis_m_tdest;
  logic [1:0]   grant_id;
  logic         busy;
  logic [15:0]  pkt_cnt;

  noc_port_arbiter #(
    .NUM_REQ (4), .TDATAW (32), .TDESTW (4), .PKT_CNTW (16)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable),
    .req_tvalid (req_tvalid), .req_tready (req_tready), .req_tdata (req_tdata),
    .req_tlast (req_tlast), .req_tdest (req_tdest),
    .axis_m_tvalid (axis_m_tvalid), .axis_m_tready (axis_m_tready),
    .axis_m_tdata (axis_m_tdata), .axis_m_tlast (axis_m_tlast),
    .axis_m_tdest (axis_m_tdest), .grant_id (grant_id), .busy (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
    logic [1:0]  src;
  } exp_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] n;
    logic [7:0] ord;
  } rr_vec_t;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     out_cnt = 0;
  logic   sb_off = 1'b0;
  logic   grant_chk = 1'b1;
  logic [3:0] hs;
  beat_t  src_q [4][$];
  exp_t   exp_q [$];
  int     out_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int src_pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic send_pkt(input int s, input int n, input logic [31:0] base,
                          input logic [3:0] d0, input logic [3:0] dl, input logic expect_out);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b.data = base + 32'(k);
      b.dest = (k == 0) ? d0 : dl;
      b.last = (k == n - 1);
      src_q[s].push_back(b);
      if (expect_out) begin
        e.data = b.data;
        e.dest = d0;
        e.last = b.last;
        e.src  = 2'(s);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0 || src_pending() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: %0d beats still expected, %0d unsent", name, exp_q.size(), src_pending());
    end
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(axis_m_tvalid), 64'(0));
    check({tag, "_payload"}, 64'({axis_m_tdata, axis_m_tdest, axis_m_tlast}), 64'(0));
    check({tag, "_req_tready"}, 64'(req_tready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(0));
  endtask

  task automatic flush_queues();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_queues();
    tick(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);
  endtask

  // Requester model: drop the head beat after a handshake, present the next one.
  initial begin
    req_tvalid = '0;
    req_tdata  = '0;
    req_tlast  = '0;
    req_tdest  = '0;
    forever begin
      @(negedge clk);
      hs = req_tvalid & req_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_tvalid[i]          = 1'b1;
          req_tdata[i*32 +: 32]  = src_q[i][0].data;
          req_tdest[i*4 +: 4]    = src_q[i][0].dest;
          req_tlast[i]           = src_q[i][0].last;
        end else begin
          req_tvalid[i] = 1'b0;
          req_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on every handshake plus AXIS hold rule.
  initial begin
    logic        prev_stall;
    logic [36:0] prev_pl;
    exp_t        e;
    prev_stall = 1'b0;
    prev_pl    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold_under_backpressure",
                64'({axis_m_tvalid, axis_m_tdata, axis_m_tdest, axis_m_tlast}),
                64'({1'b1, prev_pl}));
        if (axis_m_tvalid && axis_m_tready) begin
          out_cnt++;
          out_cyc_q.push_back(cyc);
          if (!sb_off) begin
            if (exp_q.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL unexpected_beat: data 0x%0h arrived with nothing expected", axis_m_tdata);
            end else begin
              e = exp_q.pop_front();
              check("beat_payload", 64'({axis_m_tdata, axis_m_tdest, axis_m_tlast}),
                    64'({e.data, e.dest, e.last}));
              if (grant_chk) check("beat_grant_id", 64'(grant_id), 64'(e.src));
            end
          end
        end
        prev_stall = axis_m_tvalid & ~axis_m_tready;
        prev_pl    = {axis_m_tdata, axis_m_tdest, axis_m_tlast};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rr_vec_t tbl [7];
    exp_t    e;
    int      t0, oc, k, id;

    // Round-robin vectors from the reset pointer (NUM_REQ-1): requesters in mask
    // each offer one single-beat packet; ord lists expected winners, 2 bits each.
    tbl[0] = '{mask: 4'b1111, n: 3'd4, ord: 8'hE4};  // 0,1,2,3
    tbl[1] = '{mask: 4'b1010, n: 3'd2, ord: 8'h0D};  // 1,3
    tbl[2] = '{mask: 4'b0100, n: 3'd1, ord: 8'h02};  // 2
    tbl[3] = '{mask: 4'b1001, n: 3'd2, ord: 8'h03};  // 3,0
    tbl[4] = '{mask: 4'b0110, n: 3'd2, ord: 8'h09};  // 1,2
    tbl[5] = '{mask: 4'b1101, n: 3'd3, ord: 8'h23};  // 3,0,2
    tbl[6] = '{mask: 4'b0011, n: 3'd2, ord: 8'h04};  // 0,1

    rst_n         = 1'b0;
    enable        = 1'b1;
    axis_m_tready = 1'b1;
    do_reset();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++)
        if (tbl[v].mask[i])
          send_pkt(i, 1, 32'hA000_0000 | (32'(v) << 4) | 32'(i), 4'(i), 4'(i), 1'b0);
      for (int j = 0; j < int'(tbl[v].n); j++) begin
        id     = 32'(tbl[v].ord[2*j +: 2]);
        e.data = 32'hA000_0000 | (32'(v) << 4) | 32'(id);
        e.dest = 4'(id);
        e.last = 1'b1;
        e.src  = 2'(id);
        exp_q.push_back(e);
      end
      wait_drain("rr_table", 60);
    end
    check("rr_table_pkt_cnt", 64'(pkt_cnt), 64'(16));

    // Single 3-beat packet: latency and packet count.
    do_reset();
    out_cyc_q.delete();
    send_pkt(0, 3, 32'h0000_00A0, 4'h1, 4'h1, 1'b1);
    k = 0;
    while (!req_tvalid[0] && k < 10) begin
      tick();
      k++;
    end
    t0 = cyc;
    wait_drain("t1", 40);
    check("t1_beat_count", 64'(out_cyc_q.size()), 64'(3));
    if (out_cyc_q.size() >= 3) begin
      check("t1_first_beat_cycle", 64'(out_cyc_q[0] - t0), 64'(2));
      check("t1_second_beat_cycle", 64'(out_cyc_q[1] - t0), 64'(3));
      check("t1_last_beat_cycle", 64'(out_cyc_q[2] - t0), 64'(4));
    end
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'(1));

    // Two requesters holding packets from reset alternate without interleaving.
    do_reset();
    send_pkt(0, 2, 32'h0000_0B00, 4'h2, 4'h2, 1'b1);
    send_pkt(2, 2, 32'h0000_0B20, 4'h6, 4'h6, 1'b1);
    send_pkt(0, 2, 32'h0000_0B40, 4'h2, 4'h2, 1'b1);
    send_pkt(2, 2, 32'h0000_0B60, 4'h6, 4'h6, 1'b1);
    wait_drain("t2", 60);
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'(4));

    // Mid-packet backpressure for 5 cycles.
    grant_chk = 1'b0;
    oc = out_cnt;
    send_pkt(0, 6, 32'h0000_0C00, 4'h5, 4'h5, 1'b1);
    k = 0;
    while (out_cnt == oc && k < 20) begin
      tick();
      k++;
    end
    check("t3_first_beat_seen", 64'(out_cnt - oc), 64'(1));
    axis_m_tready = 1'b0;
    tick(3);
    check("t3_req_tready_low", 64'(req_tready[0]), 64'(0));
    check("t3_no_beats_while_stalled", 64'(out_cnt - oc), 64'(1));
    tick(2);
    axis_m_tready = 1'b1;
    wait_drain("t3", 40);
    grant_chk = 1'b1;
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'(5));

    // TDEST is taken from the first beat only.
    send_pkt(1, 3, 32'h0000_0D00, 4'h3, 4'hA, 1'b1);
    wait_drain("t4", 40);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'(6));

    // ENABLE low mid-packet: req1 finishes, req3 waits for ENABLE.
    send_pkt(1, 4, 32'h0000_0E00, 4'h7, 4'h7, 1'b1);
    k = 0;
    while (!(busy && grant_id == 2'd1) && k < 20) begin
      tick();
      k++;
    end
    enable = 1'b0;
    send_pkt(3, 2, 32'h0000_0E80, 4'h9, 4'h9, 1'b1);
    k = 0;
    while (exp_q.size() > 2 && k < 30) begin
      tick();
      k++;
    end
    tick(4);
    check("t5_not_busy", 64'(busy), 64'(0));
    check("t5_grant_held", 64'(grant_id), 64'(1));
    check("t5_req3_waiting", 64'(exp_q.size()), 64'(2));
    check("t5_req_tready_low", 64'(req_tready), 64'(0));
    enable = 1'b1;
    wait_drain("t5", 40);
    check("t5_grant_req3", 64'(grant_id), 64'(3));
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'(8));

    // Reset on beat 2 of a 4-beat packet, then a clean single-beat packet.
    sb_off = 1'b1;
    oc = out_cnt;
    send_pkt(0, 4, 32'h0000_0F00, 4'h2, 4'h2, 1'b0);
    k = 0;
    while (out_cnt < oc + 2 && k < 20) begin
      tick();
      k++;
    end
    check("t6_reached_beat2", 64'(out_cnt - oc >= 2), 64'(1));
    rst_n = 1'b0;
    flush_queues();
    tick(1);
    check_reset_outputs("t6_midpkt_reset");
    tick(1);
    rst_n  = 1'b1;
    sb_off = 1'b0;
    tick(1);
    send_pkt(0, 1, 32'h0000_0F80, 4'h4, 4'h4, 1'b1);
    wait_drain("t6", 30);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
